// File: rtl/turn_signal_monitor.sv
// Passive checker for the 1-3-7 tail-light sweep: synchronizes and debounces the LED bus,
// tracks sweep progress per side, counts completed sweeps and flags errors. Optional WATCHDOG_EN adds a stall timer.
module turn_signal_monitor #(
  parameter int STABLE_CYCLES  = 4,
  parameter int CNT_WIDTH      = 8,
  parameter int TIMEOUT_CYCLES = 100000000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [2:0]           leftLED,
  input  logic [2:0]           rightLED,
  input  logic                 err_clr,
  output logic                 left_active,
  output logic                 right_active,
  output logic [CNT_WIDTH-1:0] left_cycles,
  output logic [CNT_WIDTH-1:0] right_cycles,
  output logic                 err_pulse,
  output logic [1:0]           err_code,
  output logic                 err_sticky
);

  localparam int FW = $clog2(STABLE_CYCLES + 1);

  typedef enum logic [2:0] {IDLE, L1, L3, L7, R1, R3, R7, RESYNC} state_e;

  logic [5:0]           sync1_q, sync2_q, cand_q, acc_q, acc_d;
  logic [FW-1:0]        flt_cnt_q, flt_cnt_d;
  logic                 chg_q, chg_d;
  state_e               state_q, state_d;
  logic                 err, inc_l, inc_r, legal, in_sweep, timeout;
  logic [1:0]           code_n;
  logic [CNT_WIDTH-1:0] lcnt_q, lcnt_d, rcnt_q, rcnt_d;
  logic                 la_q, ra_q, pulse_q, sticky_q;
  logic [1:0]           code_q;

  // Debounce: a pattern is accepted once STABLE_CYCLES equal synchronized samples have been seen.
  always_comb begin
    if (sync2_q != cand_q)                 flt_cnt_d = FW'(1);
    else if (flt_cnt_q < FW'(STABLE_CYCLES)) flt_cnt_d = flt_cnt_q + FW'(1);
    else                                   flt_cnt_d = flt_cnt_q;
    acc_d = (flt_cnt_d >= FW'(STABLE_CYCLES)) ? sync2_q : acc_q;
    chg_d = (acc_d != acc_q);
  end

  assign in_sweep = (state_q != IDLE) && (state_q != RESYNC);

  assign legal = (acc_q == 6'b000_000) ||
                 ((acc_q[2:0] == 3'b000) && (acc_q[5:3] inside {3'b001, 3'b011, 3'b111})) ||
                 ((acc_q[5:3] == 3'b000) && (acc_q[2:0] inside {3'b100, 3'b110, 3'b111}));

`ifdef WATCHDOG_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] timer_q, timer_d;

  assign timeout = in_sweep && !chg_q && (timer_q == TW'(TIMEOUT_CYCLES - 1));
  assign timer_d = (!in_sweep || chg_q || timeout) ? '0 : timer_q + TW'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) timer_q <= '0;
    else      timer_q <= timer_d;
  end
`else
  assign timeout = 1'b0;
`endif

  // NOTE: every signal driven here gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    state_d = state_q;
    err     = 1'b0;
    code_n  = 2'd0;
    inc_l   = 1'b0;
    inc_r   = 1'b0;
    if (chg_q) begin
      if (state_q == RESYNC) begin
        if (acc_q == 6'b000_000) state_d = IDLE;
      end else if (!legal) begin
        err    = 1'b1;
        code_n = 2'd1;
      end else begin
        case (state_q)
          IDLE: if (acc_q == 6'b001_000) state_d = L1;
                else if (acc_q == 6'b000_100) state_d = R1;
                else if (acc_q != 6'b000_000) begin err = 1'b1; code_n = 2'd2; end
          L1:   if (acc_q == 6'b011_000) state_d = L3;
                else if (acc_q == 6'b000_000) state_d = IDLE;
                else begin err = 1'b1; code_n = 2'd2; end
          L3:   if (acc_q == 6'b111_000) state_d = L7;
                else if (acc_q == 6'b000_000) state_d = IDLE;
                else begin err = 1'b1; code_n = 2'd2; end
          L7:   if (acc_q == 6'b000_000) begin state_d = IDLE; inc_l = 1'b1; end
                else begin err = 1'b1; code_n = 2'd2; end
          R1:   if (acc_q == 6'b000_110) state_d = R3;
                else if (acc_q == 6'b000_000) state_d = IDLE;
                else begin err = 1'b1; code_n = 2'd2; end
          R3:   if (acc_q == 6'b000_111) state_d = R7;
                else if (acc_q == 6'b000_000) state_d = IDLE;
                else begin err = 1'b1; code_n = 2'd2; end
          R7:   if (acc_q == 6'b000_000) begin state_d = IDLE; inc_r = 1'b1; end
                else begin err = 1'b1; code_n = 2'd2; end
          default: state_d = IDLE;
        endcase
      end
    end else if (timeout) begin
      err    = 1'b1;
      code_n = 2'd3;
    end
    if (err) state_d = (acc_q == 6'b000_000) ? IDLE : RESYNC;
  end

  // A clear and an increment in the same cycle leave the counter at one.
  always_comb begin
    lcnt_d = err_clr ? '0 : lcnt_q;
    rcnt_d = err_clr ? '0 : rcnt_q;
    if (inc_l && !(&lcnt_d)) lcnt_d = lcnt_d + CNT_WIDTH'(1);
    if (inc_r && !(&rcnt_d)) rcnt_d = rcnt_d + CNT_WIDTH'(1);
  end

  // NOTE: state is updated with non-blocking assignments so all flops sample pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      cand_q    <= '0;
      flt_cnt_q <= '0;
      acc_q     <= '0;
      chg_q     <= 1'b0;
      state_q   <= IDLE;
      lcnt_q    <= '0;
      rcnt_q    <= '0;
      la_q      <= 1'b0;
      ra_q      <= 1'b0;
      pulse_q   <= 1'b0;
      code_q    <= 2'd0;
      sticky_q  <= 1'b0;
    end else begin
      sync1_q   <= {leftLED, rightLED};
      sync2_q   <= sync1_q;
      cand_q    <= sync2_q;
      flt_cnt_q <= flt_cnt_d;
      acc_q     <= acc_d;
      chg_q     <= chg_d;
      state_q   <= state_d;
      lcnt_q    <= lcnt_d;
      rcnt_q    <= rcnt_d;
      la_q      <= state_d inside {L1, L3, L7};
      ra_q      <= state_d inside {R1, R3, R7};
      pulse_q   <= err;
      if (err) code_q <= code_n;
      sticky_q  <= err | (sticky_q & ~err_clr);
    end
  end

  assign left_active  = la_q;
  assign right_active = ra_q;
  assign left_cycles  = lcnt_q;
  assign right_cycles = rcnt_q;
  assign err_pulse    = pulse_q;
  assign err_code     = code_q;
  assign err_sticky   = sticky_q;

endmodule
